// File: rtl/ysyx_24090012_ifu_pkg.sv
// Shared types and constants for the prefetching instruction-fetch unit.
package ysyx_24090012_ifu_pkg;

    localparam int IFU_XLEN = 32;
    localparam int IFU_ILEN = 32;
    localparam logic [IFU_XLEN-1:0] RESET_PC = 32'h8000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_ILEN-1:0] inst;
        logic [IFU_XLEN-1:0] pc;
        logic                fault;
    } ifu_entry_t;

endpackage

// File: rtl/ysyx_24090012_sync_fifo.sv
// Circular FIFO with wrap-bit pointers; flush clears the pointers but keeps storage.
module ysyx_24090012_sync_fifo #(
    parameter int               WIDTH     = 65,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ysyx_24090012_ifu_prefetch.sv
// Instruction-fetch unit: sequential PC generation, credit-limited issue,
// in-order response buffering and redirect flush with in-flight drop counting.
module ysyx_24090012_ifu_prefetch #(
    parameter int              XLEN     = ysyx_24090012_ifu_pkg::IFU_XLEN,
    parameter int              ILEN     = ysyx_24090012_ifu_pkg::IFU_ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = ysyx_24090012_ifu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            idu_valid,
    input  logic            idu_ready,
    output logic [ILEN-1:0] idu_inst,
    output logic [XLEN-1:0] idu_pc,
    output logic            idu_fault
);

    import ysyx_24090012_ifu_pkg::*;

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
    localparam logic [AW+1:0]   DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            fault;
    } entry_t;

    ifu_state_e      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [AW:0]     outstanding;
    logic [AW:0]     drop_cnt;
    logic [AW:0]     count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            pop;
    logic            rsp_drop;
    logic            rsp_write;
    entry_t          wr_entry;
    entry_t          head;
    logic            unused_pc_bits;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits  = ^redirect_pc[1:0];

    // Buffered entries plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign mem_req_valid = (state == RUN) && !redirect_valid &&
                           (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign idu_valid = !fifo_empty;
    assign pop       = idu_valid && idu_ready && !redirect_valid;
    assign idu_inst  = head.inst;
    assign idu_pc    = head.pc;
    assign idu_fault = head.fault;

    assign rsp_drop  = mem_rsp_valid && (redirect_valid || (drop_cnt != '0));
    assign rsp_write = mem_rsp_valid && !rsp_drop;
    assign wr_entry  = '{inst: mem_rsp_data, pc: rsp_pc, fault: mem_rsp_err};

    ysyx_24090012_sync_fifo #(
        .WIDTH     ($bits(entry_t)),
        .DEPTH     (DEPTH),
        .RESET_VAL ({{ILEN{1'b0}}, RESET_PC, 1'b0})
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr_en   (rsp_write && (!fifo_full || pop)),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case (state)
                IDLE:    if (fetch_en)  state <= RUN;
                RUN:     if (!fetch_en) state <= IDLE;
                default: state <= IDLE;
            endcase

            outstanding <= outstanding + (req_fire ? CNT_ONE : '0) - (mem_rsp_valid ? CNT_ONE : '0);

            // Everything still in flight at a redirect is stale; a beat landing now is discarded directly.
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= outstanding - (mem_rsp_valid ? CNT_ONE : '0);
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
                if (rsp_drop)  drop_cnt <= drop_cnt - CNT_ONE;
                if (rsp_write) rsp_pc   <= rsp_pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090012_ifu_prefetch.sv
// Self-checking bench: memory model with variable latency plus a queue-based
// reference of what the IDU should see, directed vectors and random traffic.
module tb_ysyx_24090012_ifu_prefetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        idu_valid;
    logic        idu_ready;
    logic [31:0] idu_inst;
    logic [31:0] idu_pc;
    logic        idu_fault;

    ysyx_24090012_ifu_prefetch #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .idu_valid      (idu_valid),
        .idu_ready      (idu_ready),
        .idu_inst       (idu_inst),
        .idu_pc         (idu_pc),
        .idu_fault      (idu_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        bit          fault;
    } ent_t;

    typedef struct {
        logic [31:0] target;
        bit          err;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        bit          exp_fault;
    } tv_t;

    pend_t       pend_q[$];
    ent_t        exp_q[$];
    logic [31:0] pop_log[$];
    int          cyc, last_due, lat;
    bit          rand_lat, rand_err, run_m;
    logic [31:0] pc_m, fault_addr, last_fire_addr;
    int          checks, fails, fires, drops;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit mem_err(input logic [31:0] a);
        return (a == fault_addr) || (rand_err && (a[6:2] == 5'h1F));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_mem_req_valid", mem_req_valid, 0);
        checkOutput("rst_mem_req_addr", mem_req_addr, RST_PC);
        checkOutput("rst_idu_valid", idu_valid, 0);
        checkOutput("rst_idu_inst", idu_inst, 0);
        checkOutput("rst_idu_pc", idu_pc, RST_PC);
        checkOutput("rst_idu_fault", idu_fault, 0);
    endtask

    task automatic modelReset();
        pend_q.delete();
        exp_q.delete();
        run_m    = 1'b0;
        pc_m     = RST_PC;
        last_due = cyc;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst            = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        mem_rsp_err    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checkResetOutputs();
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: present the memory beat, check outputs, advance the reference, cross the edge.
    task automatic applyStimulus();
        bit    beat, fire_m, pop_m, exp_req_v;
        pend_t b;
        ent_t  e;
        int    stale_n, d;
        beat          = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
        mem_rsp_valid = beat;
        mem_rsp_data  = beat ? mem_data(pend_q[0].addr) : 32'h0;
        mem_rsp_err   = beat ? mem_err(pend_q[0].addr) : 1'b0;
        #1;
        stale_n = 0;
        foreach (pend_q[i]) if (pend_q[i].stale) stale_n++;
        exp_req_v = run_m && !redirect_valid && ((exp_q.size() + pend_q.size()) < DEPTH);
        checkOutput("mem_req_valid", mem_req_valid, exp_req_v);
        checkOutput("mem_req_addr", mem_req_addr, pc_m);
        checkOutput("idu_valid", idu_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            checkOutput("idu_pc", idu_pc, exp_q[0].pc);
            checkOutput("idu_inst", idu_inst, exp_q[0].inst);
            checkOutput("idu_fault", idu_fault, exp_q[0].fault);
        end
        checkOutput("outstanding", dut.outstanding, pend_q.size());
        checkOutput("drop_cnt", dut.drop_cnt, stale_n);
        if (beat && !redirect_valid && stale_n == 0)
            checkOutput("write_when_full", dut.fifo_full && !(idu_valid && idu_ready), 0);

        fire_m = exp_req_v && mem_req_ready;
        pop_m  = !redirect_valid && idu_ready && (exp_q.size() > 0);
        if (beat) b = pend_q.pop_front();
        if (redirect_valid) begin
            if (beat) drops++;
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            pc_m = {redirect_pc[31:2], 2'b00};
        end else begin
            if (pop_m) begin
                pop_log.push_back(exp_q[0].pc);
                void'(exp_q.pop_front());
            end
            if (beat) begin
                if (b.stale) begin
                    drops++;
                end else begin
                    e.inst  = mem_rsp_data;
                    e.pc    = b.addr;
                    e.fault = mem_rsp_err;
                    exp_q.push_back(e);
                end
            end
            if (fire_m) begin
                d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                b.addr  = pc_m;
                b.due   = d;
                b.stale = 1'b0;
                pend_q.push_back(b);
                fires++;
                last_fire_addr = pc_m;
                pc_m = pc_m + 32'd4;
            end
        end
        run_m = fetch_en;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tv_t tv[4];
        int  n, f0, out_before, pend_at, drops0;

        tv[0] = '{target: 32'h8000_1002, err: 1'b0, exp_pc: 32'h8000_1000, exp_next: 32'h8000_1004, exp_fault: 1'b0};
        tv[1] = '{target: 32'hFFFF_FFFC, err: 1'b1, exp_pc: 32'hFFFF_FFFC, exp_next: 32'h0000_0000, exp_fault: 1'b1};
        tv[2] = '{target: 32'h0000_0003, err: 1'b0, exp_pc: 32'h0000_0000, exp_next: 32'h0000_0004, exp_fault: 1'b0};
        tv[3] = '{target: 32'h1234_5679, err: 1'b1, exp_pc: 32'h1234_5678, exp_next: 32'h1234_567C, exp_fault: 1'b1};

        checks = 0; fails = 0; cyc = 0; fires = 0; drops = 0;
        rst = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
        idu_ready = 1'b1; lat = 1; rand_lat = 1'b0; rand_err = 1'b0; fault_addr = 32'h1;
        last_fire_addr = '0;

        // Reset and stream.
        doReset();
        fetch_en = 1'b1;
        n = 0;
        while (!idu_valid && n < 10) begin
            applyStimulus();
            n++;
        end
        checkOutput("first_valid_latency", n, 3);
        checkOutput("first_idu_pc", idu_pc, RST_PC);
        for (int i = 0; i < 8; i++) begin
            checkOutput("stream_valid", idu_valid, 1);
            applyStimulus();
        end

        // Backpressure.
        doReset();
        fetch_en = 1'b1; idu_ready = 1'b0; lat = 1;
        f0 = fires;
        repeat (12) applyStimulus();
        checkOutput("bp_requests", fires - f0, 4);
        checkOutput("bp_req_valid_low", mem_req_valid, 0);
        checkOutput("bp_fifo_full", dut.fifo_full, 1);
        idu_ready = 1'b1;
        pop_log.delete();
        f0 = fires;
        n = 0;
        while (fires == f0 && n < 10) begin
            applyStimulus();
            n++;
        end
        checkOutput("bp_resume_in_time", n < 10, 1);
        checkOutput("bp_resume_addr", last_fire_addr, 32'h8000_0010);
        n = 0;
        while (pop_log.size() < 4 && n < 10) begin
            applyStimulus();
            n++;
        end
        checkOutput("bp_pop_count", pop_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            checkOutput("bp_pop_order", pop_log[i], RST_PC + 32'(4 * i));

        // Redirect vectors with in-flight drops, misalignment, wrap and faults.
        lat = 3; idu_ready = 1'b1; fetch_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            fault_addr = tv[t].err ? tv[t].exp_pc : 32'h1;
            n = 0;
            while (pend_q.size() != 3 && n < 30) begin
                applyStimulus();
                n++;
            end
            checkOutput("tv_three_inflight", pend_q.size(), 3);
            pend_at = pend_q.size();
            drops0 = drops;
            redirect_valid = 1'b1;
            redirect_pc = tv[t].target;
            applyStimulus();
            redirect_valid = 1'b0;
            n = 0;
            while (!idu_valid && n < 30) begin
                applyStimulus();
                n++;
            end
            checkOutput("tv_idu_pc", idu_pc, tv[t].exp_pc);
            checkOutput("tv_idu_fault", idu_fault, tv[t].exp_fault);
            checkOutput("tv_drops", drops - drops0, pend_at);
            applyStimulus();
            n = 0;
            while (!idu_valid && n < 30) begin
                applyStimulus();
                n++;
            end
            checkOutput("tv_next_pc", idu_pc, tv[t].exp_next);
        end

        // Redirect, response beat and IDU handshake in the same cycle.
        fault_addr = 32'h1; lat = 2;
        n = 0;
        while (!((pend_q.size() > 0) && (pend_q[0].due <= cyc) && (exp_q.size() > 0)) && n < 30) begin
            applyStimulus();
            n++;
        end
        checkOutput("sim_setup", n < 30, 1);
        out_before = pend_q.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_2000;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("sim_drop_cnt", dut.drop_cnt, out_before - 1);
        checkOutput("sim_fifo_empty", idu_valid, 0);
        repeat (10) applyStimulus();

        // Reset mid-operation.
        lat = 3; idu_ready = 1'b0;
        n = 0;
        while (!(pend_q.size() == 2 && exp_q.size() == 2) && n < 40) begin
            applyStimulus();
            n++;
        end
        checkOutput("midrst_setup", n < 40, 1);
        doReset();
        idu_ready = 1'b1; lat = 1;
        f0 = fires;
        n = 0;
        while (fires == f0 && n < 10) begin
            applyStimulus();
            n++;
        end
        checkOutput("midrst_first_addr", last_fire_addr, RST_PC);
        repeat (6) applyStimulus();

        // Random traffic against the reference model.
        rand_lat = 1'b1; rand_err = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            fetch_en       = ($urandom_range(0, 15) != 0);
            idu_ready      = ($urandom_range(0, 3) != 0);
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            applyStimulus();
            redirect_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_24090012_ifu_prefetch.md
# ysyx_24090012_ifu_prefetch

Parametrised instruction-fetch unit with a prefetch buffer, sitting between the PC/redirect logic and the IDU. It generates sequential fetch addresses itself, keeps up to DEPTH requests in flight on a split request/response memory port, and buffers returned instructions in order. On a redirect it drops stale entries and in-flight responses without stalling the memory port.

## Interface
- XLEN, 32: address width; PC width.
- ILEN, 32: instruction width.
- DEPTH, 4: prefetch-buffer entries; power of two, ≥2. This is also the in-flight request limit.
- RESET_PC, 32'h8000_0000: fetch PC after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0); one clock domain.
- fetch_en  in  1  allow new requests; in-flight requests still complete when low.
- redirect_valid  in  1  one-cycle redirect pulse (branch, jump, trap).
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are forced to 0.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  request address.
- mem_rsp_valid  in  1  response beat; responses return in order; no backpressure on this path.
- mem_rsp_data  in  ILEN  fetched instruction.
- mem_rsp_err  in  1  access fault for this beat.
- idu_valid  out  1  buffer head valid.
- idu_ready  in  1  IDU accepts the head.
- idu_inst  out  ILEN  head instruction.
- idu_pc  out  XLEN  head PC.
- idu_fault  out  1  head carries an access fault.

## Operation
- **State machine.**
  - States: IDLE, RUN.
  - IDLE→RUN when fetch_en=1.
  - RUN→IDLE when fetch_en=0.
- **Issue.**
  - mem_req_valid = RUN && !redirect_valid && (count + outstanding < DEPTH).
  - mem_req_addr = fetch_pc. The request is held stable until mem_req_ready.
  - On acceptance: fetch_pc += 4, taken modulo 2^XLEN (wraps to 0); outstanding += 1.
- **Response path.**
  - Each mem_rsp_valid decrements outstanding.
  - If drop_cnt > 0: the beat is discarded and drop_cnt -= 1.
  - Otherwise the beat is written at the FIFO tail with {data, err, pc = rsp_pc}. rsp_pc then advances by 4.
- **FIFO.**
  - Circular, DEPTH entries, pointers one bit wider than log2(DEPTH).
  - Empty: pointers equal. Full: MSBs differ and the remaining bits are equal.
  - Write and pop in the same cycle are legal, including when full, because the credit check guarantees space.
  - A write when full without a pop cannot occur; the bench asserts this.
- **IDU handshake.** Pop on idu_valid && idu_ready. The head outputs come straight from the storage registers.
- **Redirect** (highest priority).
  - FIFO pointers clear; idu_valid=0 on the next cycle.
  - fetch_pc and rsp_pc load {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt loads outstanding minus any response arriving in that same cycle; that response is itself discarded.
  - A same-cycle idu handshake is ignored, because the entry is flushed.
  - No request is issued in the redirect cycle.
  - The redirect is honoured in IDLE as well.
- **Reset.**
  - Asynchronous; clears everything, mid-transaction included.
  - After reset: state=IDLE, fetch_pc=rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, idu_valid=0, idu_inst=0, idu_pc=RESET_PC, idu_fault=0.
  - The memory side must be reset together with this block.

## Timing
- Request acceptance in cycle t with the response in cycle t+k: idu_valid rises in cycle t+k+1. There is no bypass.
- Sustained throughput is one instruction per cycle once k+1 < DEPTH, with idu_ready held at 1.
- Redirect in cycle r:
  - First new request is issued in r+1.
  - Earliest valid new instruction is at r+2+k.
- fetch_en falling stops issue in the next cycle. Buffered entries continue to drain.
- outstanding and drop_cnt are log2(DEPTH)+1 bits wide. drop_cnt ≤ outstanding ≤ DEPTH at all times.

## Structure
- Shared package ysyx_24090012_ifu_pkg holds:
  - the state enum (IDLE, RUN);
  - the entry struct {inst, pc, fault};
  - RESET_PC.
- Sub-module ysyx_24090012_sync_fifo, parametrised on width and DEPTH, provides storage, pointers and full/empty flags.
- The top level holds the FSM, PC counters, credit logic and drop logic.

## Test plan
- **Reset and stream.** Reset, fetch_en=1, memory k=1, idu_ready=1 → mem_req_addr 0x80000000, 0x80000004, …; idu_pc follows the same sequence one instruction per cycle; first idu_valid 3 cycles after reset release.
- **Backpressure.** idu_ready=0, DEPTH=4 → exactly 4 requests issued; FIFO full; mem_req_valid stays 0. Release idu_ready → 4 pops in order, then issue resumes at 0x80000010.
- **Redirect with in-flight drops.** 3 requests outstanding, redirect_pc=0x80001002 → 3 responses dropped; next idu_pc=0x80001000; no stale instruction reaches the IDU.
- **Simultaneous events.** Redirect and mem_rsp_valid and idu handshake all in one cycle → response dropped; drop_cnt = outstanding−1; FIFO empty next cycle.
- **Wrap and fault.** redirect_pc=0xFFFFFFFC, then a response with err=1 → idu_pc 0xFFFFFFFC with idu_fault=1, followed by idu_pc 0x00000000.
- **Reset mid-operation.** rst asserted with 2 requests outstanding and FIFO half full → all outputs immediately at reset values; after release the unit fetches from 0x80000000.
